// File: rtl/ov7670_config_seq.sv
// OV7670 register configuration sequencer: walks a ROM of {addr, value} words and issues
// one SCCB write per word, with 0xFFF0 as a fixed delay and 0xFFFF as end-of-table.
module ov7670_config_seq #(
  parameter int unsigned N_MAX          = 64,
  parameter int unsigned ATRASO_CICLOS  = 500000,
  parameter int unsigned TIMEOUT_CICLOS = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [15:0] rom_dado,
  input  logic        sccb_pronto,
  output logic [5:0]  rom_endereco,
  output logic        sccb_partida,
  output logic [7:0]  sccb_endereco,
  output logic [7:0]  sccb_dado,
  output logic        ocupado,
  output logic        configurado,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned AtW = $clog2(ATRASO_CICLOS + 1);
  localparam int unsigned ToW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [AtW-1:0] AtLast   = AtW'(ATRASO_CICLOS - 1);
  localparam logic [ToW-1:0] ToLast   = ToW'(TIMEOUT_CICLOS - 1);
  localparam logic [5:0]     AddrLast = 6'(N_MAX - 1);

  typedef enum logic [3:0] {
    StInicial    = 4'd0,
    StLeRom      = 4'd1,
    StDecodifica = 4'd2,
    StEscreve    = 4'd3,
    StEsperaSccb = 4'd4,
    StAtraso     = 4'd5,
    StProximo    = 4'd6,
    StFim        = 4'd7,
    StErro       = 4'd8
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     addr_q, addr_d;
  logic [7:0]     reg_addr_q, reg_addr_d;
  logic [7:0]     reg_val_q, reg_val_d;
  logic [AtW-1:0] atraso_q, atraso_d;
  logic [ToW-1:0] timeout_q, timeout_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StInicial;
      addr_q     <= '0;
      reg_addr_q <= '0;
      reg_val_q  <= '0;
      atraso_q   <= '0;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      reg_val_q  <= reg_val_d;
      atraso_q   <= atraso_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    reg_addr_d   = reg_addr_q;
    reg_val_d    = reg_val_q;
    atraso_d     = atraso_q;
    timeout_d    = timeout_q;
    sccb_partida = 1'b0;
    ocupado      = 1'b0;
    configurado  = 1'b0;
    erro         = 1'b0;
    db_estado    = state_q;

    case (state_q)
      StInicial, StFim, StErro: begin
        configurado = (state_q == StFim);
        erro        = (state_q == StErro);
        if (iniciar) begin
          addr_d  = '0;
          state_d = StLeRom;
        end
      end
      StLeRom: begin
        ocupado = 1'b1;
        state_d = StDecodifica;
      end
      StDecodifica: begin
        ocupado = 1'b1;
        if (rom_dado == 16'hFFFF) begin
          state_d = StFim;
        end else if (rom_dado == 16'hFFF0) begin
          atraso_d = '0;
          state_d  = StAtraso;
        end else begin
          reg_addr_d = rom_dado[15:8];
          reg_val_d  = rom_dado[7:0];
          state_d    = StEscreve;
        end
      end
      StEscreve: begin
        ocupado      = 1'b1;
        sccb_partida = 1'b1;
        timeout_d    = '0;
        state_d      = StEsperaSccb;
      end
      StEsperaSccb: begin
        ocupado = 1'b1;
        // A completion arriving on the last timeout cycle still counts as success.
        if (sccb_pronto) begin
          state_d = StProximo;
        end else if (timeout_q == ToLast) begin
          state_d = StErro;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      StAtraso: begin
        ocupado = 1'b1;
        if (atraso_q == AtLast) begin
          state_d = StProximo;
        end else begin
          atraso_d = atraso_q + 1'b1;
        end
      end
      StProximo: begin
        ocupado = 1'b1;
        if (addr_q == AddrLast) begin
          state_d = StFim;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLeRom;
        end
      end
      default: begin
        db_estado = 4'b1001;
        state_d   = StInicial;
      end
    endcase
  end

  assign rom_endereco  = addr_q;
  assign sccb_endereco = reg_addr_q;
  assign sccb_dado     = reg_val_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: ROM and SCCB responder models plus a table-walk reference.
module tb_ov7670_config_seq;

  localparam int unsigned NMax    = 64;
  localparam int unsigned Atraso  = 10;
  localparam int unsigned Timeout = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [15:0] rom_dado;
  logic        sccb_pronto = 1'b0;
  logic [5:0]  rom_endereco;
  logic        sccb_partida;
  logic [7:0]  sccb_endereco;
  logic [7:0]  sccb_dado;
  logic        ocupado;
  logic        configurado;
  logic        erro;
  logic [3:0]  db_estado;

  ov7670_config_seq #(
    .N_MAX         (NMax),
    .ATRASO_CICLOS (Atraso),
    .TIMEOUT_CICLOS(Timeout)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .rom_dado     (rom_dado),
    .sccb_pronto  (sccb_pronto),
    .rom_endereco (rom_endereco),
    .sccb_partida (sccb_partida),
    .sccb_endereco(sccb_endereco),
    .sccb_dado    (sccb_dado),
    .ocupado      (ocupado),
    .configurado  (configurado),
    .erro         (erro),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  logic [15:0] rom_mem [NMax];
  always @(posedge clock) rom_dado <= rom_mem[rom_endereco];

  int n_checks = 0;
  int n_fail   = 0;

  // SCCB responder and event monitor, active 1 time unit after each rising edge.
  int         cyc = 0;
  int         resp_delay = 1;    // 0: never answer
  int         pend = 0;
  bit         force_pronto = 1'b0;
  int         n_part = 0;
  int         first_part_cyc = 0;
  int         esp_cyc = 0, at_cyc = 0, erro_cyc = 0;
  logic [3:0] prev_st = 4'd0;
  logic [7:0] q_a[$];
  logic [7:0] q_d[$];

  always begin
    @(posedge clock);
    #1;
    cyc++;
    sccb_pronto  = force_pronto;
    force_pronto = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) sccb_pronto = 1'b1;
    end
    if (sccb_partida) begin
      n_checks++;
      if (db_estado !== 4'd3 || pend != 0) begin
        n_fail++;
        $display("FAIL partida_context: state %0d pend %0d, want state 3 pend 0", db_estado, pend);
      end
      if (n_part == 0) first_part_cyc = cyc;
      n_part++;
      q_a.push_back(sccb_endereco);
      q_d.push_back(sccb_dado);
      if (resp_delay > 0) pend = resp_delay;
    end
    if (db_estado == 4'd4 && prev_st != 4'd4) esp_cyc = cyc;
    if (db_estado == 4'd5 && prev_st == 4'd2) at_cyc = cyc;
    if (db_estado == 4'd8 && prev_st != 4'd8) erro_cyc = cyc;
    prev_st = db_estado;
  end

  // Reference: walk the table as the sequencer should, listing the expected writes.
  logic [7:0] exp_a[$];
  logic [7:0] exp_d[$];

  task automatic model(input bit resp, output bit ok, output int last);
    exp_a.delete();
    exp_d.delete();
    ok   = 1'b1;
    last = NMax - 1;
    for (int i = 0; i < NMax; i++) begin
      if (rom_mem[i] == 16'hFFFF) begin
        last = i;
        return;
      end
      if (rom_mem[i] != 16'hFFF0) begin
        exp_a.push_back(rom_mem[i][15:8]);
        exp_d.push_back(rom_mem[i][7:0]);
        if (!resp) begin
          ok   = 1'b0;
          last = i;
          return;
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = {8'($urandom_range(0, 254)), 8'($urandom)};
    return w;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < NMax; i++) rom_mem[i] = 16'hFFFF;
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    iniciar = 1'b0;
    pend = 0;
    @(posedge clock); #2;
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  task automatic run_pass(input int budget, input bit inject, output bit done);
    n_part = 0;
    q_a.delete();
    q_d.delete();
    done = 1'b0;
    @(posedge clock); #2; iniciar = 1'b1;
    @(posedge clock); #2; iniciar = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (configurado || erro) begin
        done = 1'b1;
        break;
      end
      if (inject) begin
        if ($urandom_range(0, 7) == 0 && db_estado != 4'd3 && db_estado != 4'd4)
          force_pronto = 1'b1;
        if ($urandom_range(0, 7) == 0 && ocupado) iniciar = 1'b1;
      end
      @(posedge clock); #2;
      iniciar = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    n_checks++;
    if ({rom_endereco, sccb_endereco, sccb_dado} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h/%h/%h want 0", rom_endereco, sccb_endereco, sccb_dado);
    end
    n_checks++;
    if ({sccb_partida, ocupado, configurado, erro} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {sccb_partida, ocupado, configurado, erro});
    end
    n_checks++;
    if (db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", db_estado);
    end
  endtask

  task automatic test_single_write();
    bit done;
    clear_rom();
    rom_mem[0] = 16'h1280;
    resp_delay = 3;
    do_reset();
    run_pass(200, 1'b0, done);
    n_checks++;
    if (!done || n_part != 1) begin
      n_fail++;
      $display("FAIL single_count: done %0d writes %0d want 1/1", done, n_part);
    end
    n_checks++;
    if (q_a.size() == 0 || q_a[0] !== 8'h12 || q_d[0] !== 8'h80) begin
      n_fail++;
      $display("FAIL single_data: got %h/%h want 12/80", sccb_endereco, sccb_dado);
    end
    n_checks++;
    if ({configurado, ocupado, erro} !== 3'b100 || rom_endereco !== 6'd1) begin
      n_fail++;
      $display("FAIL single_end: flags %b addr %0d want 100 addr 1",
               {configurado, ocupado, erro}, rom_endereco);
    end
    n_checks++;
    if (db_estado !== 4'd7) begin
      n_fail++;
      $display("FAIL single_state: got %0d want 7", db_estado);
    end
  endtask

  task automatic test_delay();
    bit done;
    clear_rom();
    rom_mem[0] = 16'hFFF0;
    rom_mem[1] = 16'h1100;
    resp_delay = 2;
    do_reset();
    run_pass(300, 1'b0, done);
    n_checks++;
    if (!done || n_part != 1 || !configurado) begin
      n_fail++;
      $display("FAIL delay_done: done %0d writes %0d cfg %0d want 1/1/1", done, n_part, configurado);
    end
    n_checks++;
    if (first_part_cyc - at_cyc < int'(Atraso)) begin
      n_fail++;
      $display("FAIL delay_len: partida %0d cycles after atraso, want >= %0d",
               first_part_cyc - at_cyc, Atraso);
    end
    n_checks++;
    if (q_a.size() == 0 || q_a[0] !== 8'h11 || q_d[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL delay_data: got %h/%h want 11/00", sccb_endereco, sccb_dado);
    end
    n_checks++;
    if (rom_endereco !== 6'd2) begin
      n_fail++;
      $display("FAIL delay_addr: got %0d want 2", rom_endereco);
    end
  endtask

  task automatic test_timeout();
    bit done;
    clear_rom();
    rom_mem[0] = 16'hFFF0;
    rom_mem[1] = 16'h1280;
    resp_delay = 0;
    do_reset();
    run_pass(300, 1'b0, done);
    n_checks++;
    if (!done || erro !== 1'b1 || configurado !== 1'b0 || db_estado !== 4'd8) begin
      n_fail++;
      $display("FAIL timeout_flag: erro %0d cfg %0d state %0d want 1/0/8",
               erro, configurado, db_estado);
    end
    n_checks++;
    if (erro_cyc - esp_cyc != int'(Timeout)) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d want %0d", erro_cyc - esp_cyc, Timeout);
    end
    n_checks++;
    if (n_part != 1 || rom_endereco !== 6'd1) begin
      n_fail++;
      $display("FAIL timeout_where: writes %0d addr %0d want 1/1", n_part, rom_endereco);
    end
    @(posedge clock); #2; iniciar = 1'b1;
    @(posedge clock); #2; iniciar = 1'b0;
    n_checks++;
    if (rom_endereco !== 6'd0 || erro !== 1'b0 || db_estado !== 4'd1) begin
      n_fail++;
      $display("FAIL timeout_restart: addr %0d erro %0d state %0d want 0/0/1",
               rom_endereco, erro, db_estado);
    end
  endtask

  task automatic test_pronto_boundary();
    bit done;
    for (int d = 8; d <= 9; d++) begin
      clear_rom();
      rom_mem[0] = 16'h2A55;
      resp_delay = d;
      do_reset();
      run_pass(200, 1'b0, done);
      n_checks++;
      if (!done || configurado !== (d <= int'(Timeout)) || erro !== (d > int'(Timeout))) begin
        n_fail++;
        $display("FAIL pronto_edge_d%0d: cfg %0d erro %0d want %0d/%0d", d, configurado, erro,
                 d <= int'(Timeout), d > int'(Timeout));
      end
      pend = 0;
    end
  endtask

  task automatic test_full_rom();
    bit done, ok;
    int last;
    for (int i = 0; i < NMax; i++) rom_mem[i] = rand_word();
    resp_delay = $urandom_range(1, 3);
    do_reset();
    model(1'b1, ok, last);
    run_pass(3000, 1'b0, done);
    n_checks++;
    if (!done || n_part != exp_a.size() || n_part != int'(NMax)) begin
      n_fail++;
      $display("FAIL full_count: done %0d writes %0d want %0d", done, n_part, exp_a.size());
    end
    for (int i = 0; i < n_part && i < exp_a.size(); i++) begin
      n_checks++;
      if (q_a[i] !== exp_a[i] || q_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL full_write%0d: got %h/%h want %h/%h", i, q_a[i], q_d[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++;
    if (configurado !== ok || rom_endereco !== 6'(last)) begin
      n_fail++;
      $display("FAIL full_end: cfg %0d addr %0d want %0d/%0d", configurado, rom_endereco, ok, last);
    end
    @(posedge clock); #2; iniciar = 1'b1;
    @(posedge clock); #2; iniciar = 1'b0;
    n_checks++;
    if (rom_endereco !== 6'd0 || configurado !== 1'b0) begin
      n_fail++;
      $display("FAIL full_restart: addr %0d cfg %0d want 0/0", rom_endereco, configurado);
    end
  endtask

  task automatic test_random();
    bit done, ok;
    int last, len;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, NMax);
      for (int i = 0; i < NMax; i++)
        rom_mem[i] = (i >= len) ? 16'hFFFF :
                     ($urandom_range(0, 5) == 0) ? 16'hFFF0 : rand_word();
      resp_delay = $urandom_range(1, Timeout);
      do_reset();
      model(1'b1, ok, last);
      run_pass(3000, 1'b1, done);
      n_checks++;
      if (!done || n_part != exp_a.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: done %0d writes %0d want %0d", it, done, n_part, exp_a.size());
      end
      for (int i = 0; i < n_part && i < exp_a.size(); i++) begin
        n_checks++;
        if (q_a[i] !== exp_a[i] || q_d[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h", it, i, q_a[i], q_d[i],
                   exp_a[i], exp_d[i]);
        end
      end
      n_checks++;
      if (configurado !== ok || erro !== 1'b0 || ocupado !== 1'b0 || rom_endereco !== 6'(last)) begin
        n_fail++;
        $display("FAIL rand%0d_end: cfg %0d erro %0d busy %0d addr %0d want %0d/0/0/%0d",
                 it, configurado, erro, ocupado, rom_endereco, ok, last);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_rom();
    rom_mem[0] = 16'h1280;
    resp_delay = 0;
    do_reset();
    @(posedge clock); #2; iniciar = 1'b1;
    @(posedge clock); #2; iniciar = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (db_estado == 4'd4) seen = 1'b1;
      else begin
        @(posedge clock); #2;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_reach: state %0d want 4", db_estado);
    end
    reset = 1'b1;
    n_part = 0;
    @(posedge clock); #2;
    reset = 1'b0;
    force_pronto = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock); #2;
    end
    n_checks++;
    if (db_estado !== 4'd0 || n_part != 0 || ocupado !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: state %0d writes %0d busy %0d want 0/0/0", db_estado, n_part, ocupado);
    end
    n_checks++;
    if (sccb_endereco !== 8'h00 || sccb_dado !== 8'h00 || rom_endereco !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_regs: got %h/%h/%0d want 00/00/0", sccb_endereco, sccb_dado, rom_endereco);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_delay();
    test_timeout();
    test_pronto_boundary();
    test_full_rom();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 SHALL have parameter N_MAX, default 64: ROM depth in words; rom_endereco width is 6 bits.
REQ-002 SHALL have parameter ATRASO_CICLOS, default 500000: delay-entry wait, 10 ms at 50 MHz.
REQ-003 SHALL have parameter TIMEOUT_CICLOS, default 100000: maximum wait for sccb_pronto per write.
REQ-004 SHALL use one clock and a synchronous, active-high reset; clock, reset, and all other ports SHALL be as follows:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start or restart the configuration pass.
- rom_dado  in  16  ROM word: [15:8] register address, [7:0] value; valid 1 cycle after rom_endereco changes.
- sccb_pronto  in  1  1-cycle pulse from the SCCB master when a write completes.
- rom_endereco  out  6  registered ROM address.
- sccb_partida  out  1  1-cycle write request to the SCCB master.
- sccb_endereco  out  8  latched register address for the SCCB master.
- sccb_dado  out  8  latched register value for the SCCB master.
- ocupado  out  1  high while a pass is in progress.
- configurado  out  1  high when a pass finished normally.
- erro  out  1  high when a pass aborted on SCCB timeout.
- db_estado  out  4  state code, for debug.

Function
REQ-005 SHALL implement the following states, with db_estado codes: inicial 0000, le_rom 0001, decodifica 0010, escreve 0011, espera_sccb 0100, atraso 0101, proximo 0110, fim 0111, erro 1000; unused codes SHALL go to inicial and show 1001.
REQ-006 In inicial, fim and erro: iniciar=1 SHALL clear rom_endereco, configurado and erro, and move to le_rom. Otherwise the state SHALL be held.
REQ-007 iniciar SHALL be ignored in every other state.
REQ-008 le_rom SHALL last one cycle and then move to decodifica; this is the ROM read latency.
REQ-009 decodifica SHALL sample rom_dado and branch as follows:
- 16'hFFFF: move to fim.
- 16'hFFF0: clear the delay counter and move to atraso.
- any other value: latch [15:8] into sccb_endereco and [7:0] into sccb_dado, then move to escreve.
REQ-010 escreve SHALL drive sccb_partida=1 for exactly one cycle, clear the timeout counter, and move to espera_sccb.
REQ-011 espera_sccb SHALL behave as follows:
- sccb_pronto=1: move to proximo.
- otherwise, timeout counter = TIMEOUT_CICLOS-1: move to erro.
- otherwise: increment the timeout counter.
- If sccb_pronto and the timeout condition coincide, sccb_pronto SHALL win.
REQ-012 atraso SHALL count ATRASO_CICLOS cycles, then move to proximo.
REQ-013 In proximo:
- rom_endereco = N_MAX-1: move to fim without incrementing (no wrap-around).
- otherwise: increment rom_endereco and move to le_rom.
REQ-014 sccb_endereco and sccb_dado SHALL stay stable from escreve until the next decodifica.
REQ-015 Outputs SHALL be decoded from the state:
- ocupado=1 in le_rom through proximo.
- configurado=1 only in fim.
- erro=1 only in erro.
REQ-016 sccb_partida SHALL never be high outside escreve; at most one request SHALL be outstanding at a time.
REQ-017 A sccb_pronto pulse outside espera_sccb SHALL be ignored.
REQ-018 Counters SHALL be wide enough for their parameter value and SHALL saturate without overflow.

Reset
REQ-019 With reset=1 at a clock edge, the next state SHALL be inicial and all counters SHALL be zero.
REQ-020 After that reset edge: rom_endereco=0, sccb_endereco=0, sccb_dado=0, sccb_partida=0, ocupado=0, configurado=0, erro=0, db_estado=0000.
REQ-021 Reset mid-pass (any state) SHALL abort at once; no sccb_partida SHALL follow, and a fresh iniciar SHALL restart from address 0.

Verification
REQ-022 ROM {0x1280, 0xFFFF}, iniciar pulse, sccb_pronto 3 cycles after partida -> exactly one sccb_partida with endereco=0x12, dado=0x80; then configurado=1, ocupado=0, rom_endereco=1.
REQ-023 ROM {0xFFF0, 0x1100, 0xFFFF}, ATRASO_CICLOS=10 -> first sccb_partida comes no earlier than 10 cycles after leaving decodifica at address 0; sccb_endereco=0x11, sccb_dado=0x00.
REQ-024 TIMEOUT_CICLOS=8, sccb_pronto never asserted -> erro=1 exactly 8 cycles after espera_sccb is entered; then iniciar restarts at address 0 with erro=0.
REQ-025 ROM of 64 normal words with no 0xFFFF, N_MAX=64 -> 64 writes, then fim with rom_endereco=63 (no wrap).
REQ-026 reset asserted in espera_sccb, then a stray sccb_pronto -> state stays inicial, db_estado=0000, and no sccb_partida occurs until iniciar.
